prog_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 3-bit-opcode core.
- Owns the program counter and the Start/Ack run handshake with the testbench/host.
- Steps each instruction through fetch, execute and optional load-wait phases.
- Emits a single-cycle commit enable (ExecEn) that gates the decoder's RegWrite/MemWrite, and applies the decoder's Branch decision to the PC.

---
 rtl/prog_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_prog_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: multi-cycle instruction sequencer for the 3-bit-opcode core.
//
// Owns the program counter and the start/ack run handshake. Each instruction
// goes through FETCH (synchronous ROM read), EXEC (decode valid, commit) and,
// for loads when MEM_LAT > 0, MEMWAIT before committing. The single-cycle
// commit strobe exec_en_o gates RegWrite/MemWrite in the datapath.
//
// Optional feature macro: FEG_WATCHDOG_EN
//   When defined, a run that commits WDOG_LIMIT instructions without reaching
//   halt is stopped: the sequencer enters DONE with ack_o=1 and timeout_o=1.
//   When undefined, there is no limit and timeout_o is tied to 0.
//
// Ports:
//   clk_i         system clock, all state on the rising edge
//   reset_i       synchronous, active-high reset
//   start_i       run request, level-sampled in IDLE/DONE, ignored while busy
//   branch_i      decoder branch-taken, valid in the commit cycle
//   br_target_i   absolute branch target, valid in the commit cycle
//   mem_to_reg_i  decoder load flag, valid in EXEC
//   halt_i        current instruction is the halt encoding, valid in EXEC
//   pc_o          instruction ROM address
//   exec_en_o     commit strobe (decoded from state)
//   busy_o        high in FETCH/EXEC/MEMWAIT (decoded from state)
//   ack_o         program finished, held until the next start
//   cycle_cnt_o   cycles spent running in the last/current run (saturating)
//   instr_cnt_o   instructions committed in the last/current run (saturating)
//   timeout_o     watchdog fired (constant 0 without FEG_WATCHDOG_EN)

module prog_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_LIMIT = 4095
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             branch_i,
    input  logic [PC_W-1:0]  br_target_i,
    input  logic             mem_to_reg_i,
    input  logic             halt_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             exec_en_o,
    output logic             busy_o,
    output logic             ack_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned WaitW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMemWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               ack_q, ack_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               timeout_q, timeout_d;

    logic               exec_en;
    logic               busy;
    // Non-halt commit: advance the PC and return to FETCH.
    logic               commit_step;
    logic [PC_W-1:0]    pc_next;
    logic [CNT_W-1:0]   cycle_inc;
    logic [CNT_W-1:0]   instr_inc;
    logic               is_load_wait;

    // Branch target is used verbatim; sequential PC wraps modulo 2^PC_W.
    assign pc_next   = branch_i ? br_target_i : (pc_q + PC_W'(1));

    // Both counters saturate at all-ones instead of wrapping.
    assign cycle_inc = (&cycle_cnt_q) ? cycle_cnt_q : (cycle_cnt_q + CNT_W'(1));
    assign instr_inc = (&instr_cnt_q) ? instr_cnt_q : (instr_cnt_q + CNT_W'(1));

    // A load only detours through MEMWAIT when there is latency to wait out.
    assign is_load_wait = mem_to_reg_i && (MEM_LAT > 0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ack_d       = ack_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        exec_en     = 1'b0;
        busy        = 1'b0;
        commit_step = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // A new run starts from PC 0 with fresh counters; ack drops on the same edge.
                if (start_i) begin
                    state_d     = StFetch;
                    pc_d        = '0;
                    ack_d       = 1'b0;
                    cycle_cnt_d = '0;
                    instr_cnt_d = '0;
                    timeout_d   = 1'b0;
                end
            end

            StFetch: begin
                busy        = 1'b1;
                cycle_cnt_d = cycle_inc;
                state_d     = StExec;
            end

            StExec: begin
                busy        = 1'b1;
                cycle_cnt_d = cycle_inc;
                if (halt_i) begin
                    // Halt overrides branch and load; PC stays on the halt instruction.
                    exec_en     = 1'b1;
                    instr_cnt_d = instr_inc;
                    ack_d       = 1'b1;
                    state_d     = StDone;
                end else if (is_load_wait) begin
                    wait_d  = WaitW'(MEM_LAT);
                    state_d = StMemWait;
                end else begin
                    exec_en     = 1'b1;
                    commit_step = 1'b1;
                end
            end

            StMemWait: begin
                busy        = 1'b1;
                cycle_cnt_d = cycle_inc;
                wait_d      = wait_q - WaitW'(1);
                if (wait_q == WaitW'(1)) begin
                    exec_en     = 1'b1;
                    commit_step = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit_step) begin
            instr_cnt_d = instr_inc;
            pc_d        = pc_next;
            state_d     = StFetch;
`ifdef FEG_WATCHDOG_EN
            // The limiting instruction still commits; the run then stops as if halted.
            if (instr_inc == CNT_W'(WDOG_LIMIT)) begin
                state_d   = StDone;
                ack_d     = 1'b1;
                timeout_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            ack_q       <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ack_q       <= ack_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            wait_q      <= wait_d;
        end
    end

`ifdef FEG_WATCHDOG_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Without the watchdog the flag never sets; keep the register at its reset value.
    always_ff @(posedge clk_i) begin
        timeout_q <= 1'b0;
    end

    assign timeout_o = 1'b0;
`endif

    assign pc_o        = pc_q;
    assign exec_en_o   = exec_en;
    assign busy_o      = busy;
    assign ack_o       = ack_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed program table, hand-written
// multi-cycle sequences and random programs checked against an
// instruction-level reference model.

module tb_prog_sequencer;

    localparam int unsigned PcW    = 10;
    localparam int unsigned CntW   = 16;
    localparam int unsigned MemLat = 1;
    localparam int unsigned Wdog   = 5;

    // ROM word: {halt, load, branch, target[9:0]}
    localparam logic [12:0] ALU  = 13'h0000;
    localparam logic [12:0] LOAD = 13'h0800;
    localparam logic [12:0] HALT = 13'h1000;

    logic            clk_i;
    logic            reset_i;
    logic            start_i;
    logic            branch_i;
    logic [PcW-1:0]  br_target_i;
    logic            mem_to_reg_i;
    logic            halt_i;
    logic [PcW-1:0]  pc_o;
    logic            exec_en_o;
    logic            busy_o;
    logic            ack_o;
    logic [CntW-1:0] cycle_cnt_o;
    logic [CntW-1:0] instr_cnt_o;
    logic            timeout_o;

    // Second instance with no load latency.
    logic            start0;
    logic            branch0;
    logic [PcW-1:0]  br_target0;
    logic            mem_to_reg0;
    logic            halt0;
    logic [PcW-1:0]  pc0;
    logic            exec_en0;
    logic            busy0;
    logic            ack0;
    logic [CntW-1:0] cycle_cnt0;
    logic [CntW-1:0] instr_cnt0;
    logic            timeout0;

    prog_sequencer #(
        .PC_W      (PcW),
        .MEM_LAT   (MemLat),
        .CNT_W     (CntW),
        .WDOG_LIMIT(Wdog)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .branch_i    (branch_i),
        .br_target_i (br_target_i),
        .mem_to_reg_i(mem_to_reg_i),
        .halt_i      (halt_i),
        .pc_o        (pc_o),
        .exec_en_o   (exec_en_o),
        .busy_o      (busy_o),
        .ack_o       (ack_o),
        .cycle_cnt_o (cycle_cnt_o),
        .instr_cnt_o (instr_cnt_o),
        .timeout_o   (timeout_o)
    );

    prog_sequencer #(
        .PC_W      (PcW),
        .MEM_LAT   (0),
        .CNT_W     (CntW),
        .WDOG_LIMIT(Wdog)
    ) dut0 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start0),
        .branch_i    (branch0),
        .br_target_i (br_target0),
        .mem_to_reg_i(mem_to_reg0),
        .halt_i      (halt0),
        .pc_o        (pc0),
        .exec_en_o   (exec_en0),
        .busy_o      (busy0),
        .ack_o       (ack0),
        .cycle_cnt_o (cycle_cnt0),
        .instr_cnt_o (instr_cnt0),
        .timeout_o   (timeout0)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    logic [12:0] rom [1024];
    logic [9:0]  got_q [$];
    logic [9:0]  exp_q [$];
    int          exp_cyc;
    int          exp_n;
    logic [9:0]  exp_pc;
    logic        exp_to;
    int          n_checks = 0;
    int          n_errs   = 0;

    typedef struct {
        logic [3:0][12:0] prog;   // element 0 is the word at PC 0
        int               cyc;
        int               n;
        logic [9:0]       pc;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [12:0] br(input logic [9:0] t);
        return 13'h0400 | {3'b000, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The bench plays the instruction ROM plus decoder for both instances.
    task automatic drive_inputs();
        logic [12:0] r;
        r            = rom[pc_o];
        halt_i       = r[12];
        mem_to_reg_i = r[11];
        branch_i     = r[10];
        br_target_i  = r[9:0];
        r            = rom[pc0];
        halt0        = r[12];
        mem_to_reg0  = r[11];
        branch0      = r[10];
        br_target0   = r[9:0];
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        drive_inputs();
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = HALT;
    endtask

    // Instruction-level model of a run from PC 0 over the current ROM.
    task automatic model();
        logic [9:0]  pc;
        logic [12:0] r;
        int          n;
        int          cyc;
        exp_q.delete();
        pc     = '0;
        n      = 0;
        cyc    = 0;
        exp_to = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            r = rom[pc];
            exp_q.push_back(pc);
            n++;
            if (r[12]) begin
                cyc += 2;
                break;
            end
            cyc += r[11] ? (2 + MemLat) : 2;
            pc = r[10] ? r[9:0] : (pc + 10'd1);
`ifdef FEG_WATCHDOG_EN
            if (n == Wdog) begin
                exp_to = 1'b1;
                break;
            end
`endif
        end
        exp_cyc = cyc;
        exp_n   = n;
        exp_pc  = pc;
    endtask

    // Start a run and follow it to ack, recording the PC of every commit.
    task automatic run_prog(input bit hold, input int bound, output int cycles);
        bit ok;
        got_q.delete();
        ok      = 1'b0;
        cycles  = 0;
        start_i = 1'b1;
        tick();
        if (!hold) start_i = 1'b0;
        while (cycles < bound) begin
            if (ack_o) begin
                ok = 1'b1;
                break;
            end
            if (exec_en_o) got_q.push_back(pc_o);
            tick();
            cycles++;
        end
        start_i = 1'b0;
        if (!ok) chk("run_reached_ack", 32'(ack_o), 32'd1);
    endtask

    task automatic check_run(input string tag, input int cycles);
        int nbad;
        model();
        chk({tag, "_cycle_cnt"}, 32'(cycle_cnt_o), 32'(exp_cyc));
        chk({tag, "_instr_cnt"}, 32'(instr_cnt_o), 32'(exp_n));
        chk({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_cyc));
        chk({tag, "_pc"}, 32'(pc_o), 32'(exp_pc));
        chk({tag, "_ack"}, 32'(ack_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'(exp_to));
        chk({tag, "_commits"}, 32'(got_q.size()), 32'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) nbad++;
        end
        chk({tag, "_commit_pcs"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int cycles;
        int cnt;
        int commits;

        vecs[0] = '{prog: {HALT, ALU, ALU, ALU},           cyc: 8,  n: 4, pc: 10'd3};
        vecs[1] = '{prog: {HALT, HALT, HALT, LOAD},        cyc: 5,  n: 2, pc: 10'd1};
        vecs[2] = '{prog: {HALT, ALU, ALU, br(10'd3)},     cyc: 4,  n: 2, pc: 10'd3};
        vecs[3] = '{prog: {ALU, ALU, ALU, HALT | LOAD | br(10'h2A)}, cyc: 2, n: 1, pc: 10'd0};
        vecs[4] = '{prog: {HALT, LOAD, LOAD, ALU},         cyc: 10, n: 4, pc: 10'd3};
        vecs[5] = '{prog: {HALT, ALU, ALU, LOAD | br(10'd3)}, cyc: 5, n: 2, pc: 10'd3};

        clear_rom();
        reset_i = 1'b1;
        start_i = 1'b0;
        start0  = 1'b0;
        drive_inputs();
        tick();
        tick();
        tick();
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_exec_en", 32'(exec_en_o), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
        chk("rst_instr_cnt", 32'(instr_cnt_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // Directed program table
        for (int v = 0; v < 6; v++) begin
            clear_rom();
            for (int i = 0; i < 4; i++) rom[i] = vecs[v].prog[i];
            run_prog(v[0], 100, cycles);
            chk($sformatf("vec%0d_cycle_cnt", v), 32'(cycle_cnt_o), 32'(vecs[v].cyc));
            chk($sformatf("vec%0d_instr_cnt", v), 32'(instr_cnt_o), 32'(vecs[v].n));
            chk($sformatf("vec%0d_commits", v), 32'(got_q.size()), 32'(vecs[v].n));
            chk($sformatf("vec%0d_busy_cycles", v), 32'(cycles), 32'(vecs[v].cyc));
            chk($sformatf("vec%0d_pc", v), 32'(pc_o), 32'(vecs[v].pc));
            chk($sformatf("vec%0d_ack", v), 32'(ack_o), 32'd1);
        end

        // DONE holds without start, restarts cleanly with it
        tick();
        chk("done_hold_ack", 32'(ack_o), 32'd1);
        chk("done_hold_pc", 32'(pc_o), 32'd3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_ack", 32'(ack_o), 32'd0);
        chk("restart_pc", 32'(pc_o), 32'd0);
        chk("restart_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
        chk("restart_instr_cnt", 32'(instr_cnt_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Reset held mid-run at PC 5
        clear_rom();
        for (int i = 0; i < 10; i++) rom[i] = ALU;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cnt = 0;
        while (pc_o != 10'd5 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("midrst_reach_pc5", 32'(pc_o), 32'd5);
        reset_i = 1'b1;
        tick();
        chk("midrst_pc", 32'(pc_o), 32'd0);
        chk("midrst_ack", 32'(ack_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_exec_en", 32'(exec_en_o), 32'd0);
        chk("midrst_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
        chk("midrst_instr_cnt", 32'(instr_cnt_o), 32'd0);
        tick();
        tick();
        reset_i = 1'b0;
        tick();

        // Branch at PC 7 to 0x2A
        clear_rom();
        rom[0] = br(10'd6);
        rom[6] = ALU;
        rom[7] = br(10'h2A);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cnt = 0;
        while (!(pc_o == 10'd7 && exec_en_o) && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("br7_commit_seen", 32'(exec_en_o), 32'd1);
        tick();
        chk("br7_fetch_pc", 32'(pc_o), 32'h2A);
        chk("br7_fetch_exec_en", 32'(exec_en_o), 32'd0);
        chk("br7_fetch_busy", 32'(busy_o), 32'd1);
        cnt = 0;
        while (!ack_o && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("br7_ack", 32'(ack_o), 32'd1);
        chk("br7_done_pc", 32'(pc_o), 32'h2A);

        // PC wrap at 0x3FF
        clear_rom();
        rom[0]     = br(10'h3FF);
        rom[10'h3FF] = ALU;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cnt = 0;
        while (!(pc_o == 10'h3FF && exec_en_o) && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("wrap_commit_seen", 32'(exec_en_o), 32'd1);
        tick();
        chk("wrap_pc", 32'(pc_o), 32'd0);
        chk("wrap_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Load then halt with no load latency
        clear_rom();
        rom[0] = LOAD;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cnt     = 0;
        commits = 0;
        while (!ack0 && cnt < 50) begin
            if (exec_en0) commits++;
            tick();
            cnt++;
        end
        chk("lat0_ack", 32'(ack0), 32'd1);
        chk("lat0_cycle_cnt", 32'(cycle_cnt0), 32'd4);
        chk("lat0_instr_cnt", 32'(instr_cnt0), 32'd2);
        chk("lat0_busy_cycles", 32'(cnt), 32'd4);
        chk("lat0_commits", 32'(commits), 32'd2);
        chk("lat0_pc", 32'(pc0), 32'd1);

        // Endless loop: watchdog stops it, or it keeps running
        clear_rom();
        rom[0] = ALU;
        rom[1] = br(10'd0);
`ifdef FEG_WATCHDOG_EN
        run_prog(1'b0, 200, cycles);
        check_run("wdog", cycles);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("wdog_restart_timeout", 32'(timeout_o), 32'd0);
`else
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        commits = 0;
        for (int i = 0; i < 240; i++) begin
            if (exec_en_o) commits++;
            tick();
        end
        chk("nowdog_busy", 32'(busy_o), 32'd1);
        chk("nowdog_timeout", 32'(timeout_o), 32'd0);
        chk("nowdog_instr_cnt", 32'(instr_cnt_o), 32'(commits));
        chk("nowdog_past_100", 32'(commits > 100), 32'd1);
`endif
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();

        // Random forward-branching programs ending in halt
        for (int r = 0; r < 20; r++) begin
            int          len;
            bit          hold;
            logic [12:0] w;
            clear_rom();
            len = int'($urandom_range(2, 12));
            for (int i = 0; i < len - 1; i++) begin
                w = ALU;
                if ($urandom_range(0, 2) == 0) w[11] = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    w[10]  = 1'b1;
                    w[9:0] = 10'($urandom_range(i + 1, len - 1));
                end
                rom[i] = w;
            end
            w      = HALT;
            w[11]  = 1'($urandom_range(0, 1));
            w[10]  = 1'($urandom_range(0, 1));
            w[9:0] = 10'($urandom);
            rom[len - 1] = w;
            hold = 1'($urandom_range(0, 1));
            run_prog(hold, 400, cycles);
            check_run($sformatf("rnd%0d", r), cycles);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
